// File: rtl/game_turn_controller.sv
// Connect-4 turn sequencer. It accepts column drops, tracks column heights and the move count,
// issues accepted moves to the win checker, and resolves turn hand-off, win and tie.
module game_turn_controller #(
  parameter int COLS = 7,
  parameter int ROWS = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       drop,
  input  logic [2:0] col,
  input  logic       check_done,
  input  logic       win,
  output logic [1:0] state,
  output logic [1:0] game_status,
  output logic       move_valid,
  output logic [2:0] move_col,
  output logic [2:0] move_row,
  output logic [1:0] move_player,
  output logic       move_reject,
  output logic       busy
);

  typedef enum logic [1:0] {
    GAME_INIT = 2'b00,
    P1_TURN   = 2'b01,
    P2_TURN   = 2'b10,
    END_GAME  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    STILL_PLAYING = 2'b00,
    P1_WINS       = 2'b01,
    P2_WINS       = 2'b10,
    TIE           = 2'b11
  } status_t;

  localparam logic [5:0] CELLS  = 6'(ROWS * COLS);
  localparam logic [2:0] ROWS_H = 3'(ROWS);
  localparam logic [3:0] COLS_W = 4'(COLS);

  state_t     state_q;
  status_t    status_q;
  logic [5:0] move_count;
  // Eight entries so any 3-bit col indexes safely; entries at or above COLS stay zero.
  logic [2:0] heights [8];
  logic       legal;

  assign legal       = ({1'b0, col} < COLS_W) && (heights[col] < ROWS_H);
  assign state       = state_q;
  assign game_status = status_q;

  // NOTE: the height table is a handful of flops, not a RAM, so it is cleared by reset
  // like the rest of the state; a real memory array would be left out of the reset branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= GAME_INIT;
      status_q    <= STILL_PLAYING;
      move_count  <= '0;
      move_valid  <= 1'b0;
      move_reject <= 1'b0;
      move_col    <= '0;
      move_row    <= '0;
      move_player <= '0;
      busy        <= 1'b0;
      for (int i = 0; i < 8; i++) heights[i] <= '0;
    end else begin
      move_valid  <= 1'b0;
      move_reject <= 1'b0;
      case (state_q)
        GAME_INIT: begin
          if (start) begin
            state_q    <= P1_TURN;
            move_count <= '0;
            for (int i = 0; i < 8; i++) heights[i] <= '0;
          end
        end
        P1_TURN, P2_TURN: begin
          // While a check is outstanding only check_done matters; drops vanish silently.
          if (busy) begin
            if (check_done) begin
              busy <= 1'b0;
              if (win) begin
                state_q  <= END_GAME;
                status_q <= status_t'(move_player);
              end else if (move_count == CELLS) begin
                state_q  <= END_GAME;
                status_q <= TIE;
              end else begin
                state_q <= (state_q == P1_TURN) ? P2_TURN : P1_TURN;
              end
            end
          end else if (drop) begin
            if (legal) begin
              move_valid   <= 1'b1;
              move_col     <= col;
              move_row     <= heights[col];
              move_player  <= state_q;
              heights[col] <= heights[col] + 3'd1;
              move_count   <= move_count + 6'd1;
              busy         <= 1'b1;
            end else begin
              move_reject <= 1'b1;
            end
          end
        end
        END_GAME: begin
          if (start) begin
            state_q    <= GAME_INIT;
            status_q   <= STILL_PLAYING;
            move_count <= '0;
            for (int i = 0; i < 8; i++) heights[i] <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_turn_controller.sv
// Directed bench for game_turn_controller: expected move events go into a scoreboard queue
// that a negedge monitor drains; state/status checks are made inline by the stimulus thread.
module tb_game_turn_controller;

  logic       clk = 1'b0;
  logic       rst, start, drop, check_done, win;
  logic [2:0] col;
  logic [1:0] state, game_status, move_player;
  logic       move_valid, move_reject, busy;
  logic [2:0] move_col, move_row;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic       is_reject;
    logic [2:0] col;
    logic [2:0] row;
    logic [1:0] player;
  } exp_t;

  exp_t sb[$];

  localparam logic [1:0] S_INIT = 2'b00, S_P1 = 2'b01, S_P2 = 2'b10, S_END = 2'b11;
  localparam logic [1:0] G_PLAY = 2'b00, G_P1 = 2'b01, G_P2 = 2'b10, G_TIE = 2'b11;

  game_turn_controller #(.COLS(7), .ROWS(6)) dut (
    .clk(clk), .rst(rst), .start(start), .drop(drop), .col(col),
    .check_done(check_done), .win(win), .state(state), .game_status(game_status),
    .move_valid(move_valid), .move_col(move_col), .move_row(move_row),
    .move_player(move_player), .move_reject(move_reject), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every move_valid/move_reject pulse must match the oldest expected event.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && (move_valid || move_reject)) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_event: got valid=%0b reject=%0b col=%0d expected none",
                   move_valid, move_reject, move_col);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("event_reject", {7'd0, move_reject}, {7'd0, e.is_reject});
          check("event_valid", {7'd0, move_valid}, {7'd0, !e.is_reject});
          if (!e.is_reject) begin
            check("move_col", {5'd0, move_col}, {5'd0, e.col});
            check("move_row", {5'd0, move_row}, {5'd0, e.row});
            check("move_player", {6'd0, move_player}, {6'd0, e.player});
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drop into column c; kind 0 = expect accept, 1 = expect reject, 2 = expect nothing.
  task automatic do_drop(input logic [2:0] c, input int kind,
                         input logic [2:0] row, input logic [1:0] player);
    exp_t e;
    if (kind != 2) begin
      e.is_reject = (kind == 1);
      e.col       = c;
      e.row       = row;
      e.player    = player;
      sb.push_back(e);
    end
    drop = 1'b1;
    col  = c;
    tick();
    drop = 1'b0;
  endtask

  task automatic do_check(input logic w);
    check_done = 1'b1;
    win        = w;
    tick();
    check_done = 1'b0;
    win        = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, {6'd0, state}, {6'd0, S_INIT});
    check({tag, "_status"}, {6'd0, game_status}, {6'd0, G_PLAY});
    check({tag, "_busy"}, {7'd0, busy}, 8'd0);
    check({tag, "_move_valid"}, {7'd0, move_valid}, 8'd0);
    check({tag, "_move_reject"}, {7'd0, move_reject}, 8'd0);
    check({tag, "_move_fields"}, {move_col, move_row, move_player}, 8'd0);
  endtask

  // Fill the whole board column by column; last_win is the checker reply for move 42.
  task automatic fill_board(input logic last_win, input logic [1:0] exp_status);
    for (int i = 0; i < 42; i++) begin
      logic [1:0] p;
      p = (i % 2 == 0) ? S_P1 : S_P2;
      check("fill_turn", {6'd0, state}, {6'd0, p});
      do_drop(3'(i / 6), 0, 3'(i % 6), p);
      do_check((i == 41) ? last_win : 1'b0);
    end
    check("fill_end_state", {6'd0, state}, {6'd0, S_END});
    check("fill_end_status", {6'd0, game_status}, {6'd0, exp_status});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; drop = 1'b0; col = '0; check_done = 1'b0; win = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check_idle("reset");

    // 1: start, first move, hand-off to P2
    pulse_start();
    check("start_state", {6'd0, state}, {6'd0, S_P1});
    do_drop(3'd3, 0, 3'd0, S_P1);
    check("busy_after_drop", {7'd0, busy}, 8'd1);
    do_check(1'b0);
    check("handoff_state", {6'd0, state}, {6'd0, S_P2});
    check("handoff_busy", {7'd0, busy}, 8'd0);

    // 2: fill column 0, seventh drop rejected
    for (int i = 0; i < 6; i++) begin
      do_drop(3'd0, 0, 3'(i), (i % 2 == 0) ? S_P2 : S_P1);
      do_check(1'b0);
    end
    do_drop(3'd0, 1, 3'd0, 2'd0);
    check("full_col_state", {6'd0, state}, {6'd0, S_P2});
    check("full_col_busy", {7'd0, busy}, 8'd0);
    do_drop(3'd0, 1, 3'd0, 2'd0);

    // 3: out-of-range column, drops while busy, check_done racing a drop
    do_drop(3'd7, 1, 3'd0, 2'd0);
    do_drop(3'd1, 0, 3'd0, S_P2);
    do_drop(3'd2, 2, 3'd0, 2'd0);
    drop = 1'b1; col = 3'd2;
    do_check(1'b0);
    drop = 1'b0;
    check("race_state", {6'd0, state}, {6'd0, S_P1});
    check("race_busy", {7'd0, busy}, 8'd0);
    do_check(1'b0);
    check("idle_check_ignored", {6'd0, state}, {6'd0, S_P1});
    pulse_start();
    check("midgame_start_ignored", {6'd0, state}, {6'd0, S_P1});

    // 4: P1 wins, drop ignored in END_GAME, start returns to GAME_INIT
    do_drop(3'd4, 0, 3'd0, S_P1);
    do_check(1'b1);
    check("win_state", {6'd0, state}, {6'd0, S_END});
    check("win_status", {6'd0, game_status}, {6'd0, G_P1});
    do_drop(3'd5, 2, 3'd0, 2'd0);
    check("end_hold_state", {6'd0, state}, {6'd0, S_END});
    check("move_col_held", {5'd0, move_col}, 8'd4);
    pulse_start();
    check("restart_state", {6'd0, state}, {6'd0, S_INIT});
    check("restart_status", {6'd0, game_status}, {6'd0, G_PLAY});

    // 5: full board tie, then full board with a win on the last move
    pulse_start();
    fill_board(1'b0, G_TIE);
    do_drop(3'd6, 2, 3'd0, 2'd0);
    pulse_start();
    pulse_start();
    fill_board(1'b1, G_P2);
    pulse_start();

    // 6: reset while a check is outstanding
    pulse_start();
    do_drop(3'd2, 0, 3'd0, S_P1);
    check("pre_reset_busy", {7'd0, busy}, 8'd1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_idle("async_reset");
    tick();
    rst = 1'b0;
    do_check(1'b1);
    check_idle("post_reset_check");

    repeat (3) tick();
    check("scoreboard_drained", 8'(sb.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
